// File: rtl/dense_axis_bridge.sv
// AXI-Stream wrapper for the dense layer: buffers one input frame, starts the datapath, drains its results.
// Optional framing check on s_axis_tlast is enabled by defining DENSE_AXIS_BRIDGE_TLAST_CHECK_EN.
module dense_axis_bridge #(
    parameter int IN_COUNT  = 16,
    parameter int OUT_COUNT = 10,
    parameter int DATA_SIZE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_SIZE-1:0]         s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [DATA_SIZE-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    input  logic [$clog2(IN_COUNT)-1:0]  bufferIn_adr,
    output logic [DATA_SIZE-1:0]         bufferIn_data,
    input  logic [$clog2(OUT_COUNT)-1:0] bufferOut_adr,
    input  logic [DATA_SIZE-1:0]         bufferOut_data,
    input  logic                         bufferOut_wr,
    output logic                         dense_start,
    input  logic                         dense_done,
    output logic                         err
);

    localparam int IN_W  = $clog2(IN_COUNT);
    localparam int OUT_W = $clog2(OUT_COUNT);

    typedef enum logic [1:0] {RECV, START, CALC, SEND} state_t;

    state_t               state_q, state_d;
    logic [IN_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [OUT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [DATA_SIZE-1:0] in_buf_q  [IN_COUNT];
    logic [DATA_SIZE-1:0] out_buf_q [OUT_COUNT];
    logic [IN_COUNT-1:0]  in_we;
    logic [OUT_COUNT-1:0] out_we;
    logic                 s_hs, m_hs, in_last, out_last;

    assign s_axis_tready = (state_q == RECV) && !rst;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign in_last       = (wr_cnt_q == IN_W'(IN_COUNT - 1));
    assign m_axis_tvalid = (state_q == SEND);
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign out_last      = (rd_cnt_q == OUT_W'(OUT_COUNT - 1));
    assign m_axis_tlast  = m_axis_tvalid && out_last;
    assign dense_start   = (state_q == START);

    // Per-entry write enables; out-of-range addresses simply match no entry.
    generate
        for (genvar gi = 0; gi < IN_COUNT; gi++) begin : g_in_we
            assign in_we[gi] = s_hs && (wr_cnt_q == IN_W'(gi));
        end
        for (genvar gi = 0; gi < OUT_COUNT; gi++) begin : g_out_we
            assign out_we[gi] = (state_q == CALC) && bufferOut_wr && (bufferOut_adr == OUT_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_COUNT; i++) begin
            if (in_we[i]) in_buf_q[i] <= s_axis_tdata;
        end
        for (int i = 0; i < OUT_COUNT; i++) begin
            if (out_we[i]) out_buf_q[i] <= bufferOut_data;
        end
    end

    always_comb begin
        bufferIn_data = '0;
        for (int i = 0; i < IN_COUNT; i++) begin
            if (bufferIn_adr == IN_W'(i)) bufferIn_data = in_buf_q[i];
        end
    end

    // Data is forced to zero whenever no beat is being presented.
    always_comb begin
        m_axis_tdata = '0;
        for (int i = 0; i < OUT_COUNT; i++) begin
            if (m_axis_tvalid && rd_cnt_q == OUT_W'(i)) m_axis_tdata = out_buf_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            RECV: begin
                if (s_hs) begin
                    if (in_last) begin
                        wr_cnt_d = '0;
                        state_d  = START;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            START: state_d = CALC;
            CALC: begin
                if (dense_done) state_d = SEND;
            end
            SEND: begin
                if (m_hs) begin
                    if (out_last) begin
                        rd_cnt_d = '0;
                        state_d  = RECV;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RECV;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

`ifdef DENSE_AXIS_BRIDGE_TLAST_CHECK_EN
    logic err_q, err_d;

    // Sticky: tlast must coincide exactly with the IN_COUNT-th beat.
    always_comb begin
        err_d = err_q | (s_hs && (s_axis_tlast != in_last));
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_dense_axis_bridge.sv
// Directed bench for dense_axis_bridge with IN_COUNT=4, OUT_COUNT=3, DATA_SIZE=8.
module tb_dense_axis_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tready, s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid, m_tready, m_tlast;
    logic [1:0] in_adr;
    logic [7:0] in_data;
    logic [1:0] out_adr;
    logic [7:0] out_data;
    logic       out_wr, dense_start, dense_done, err;

`ifdef DENSE_AXIS_BRIDGE_TLAST_CHECK_EN
    localparam bit TLAST_CHK = 1'b1;
`else
    localparam bit TLAST_CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    dense_axis_bridge #(.IN_COUNT(4), .OUT_COUNT(3), .DATA_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .bufferIn_adr(in_adr), .bufferIn_data(in_data),
        .bufferOut_adr(out_adr), .bufferOut_data(out_data), .bufferOut_wr(out_wr),
        .dense_start(dense_start), .dense_done(dense_done), .err(err)
    );

    typedef struct {
        logic       rst, sv; logic [7:0] sd; logic sl, mr;
        logic [1:0] ia, oa; logic [7:0] od; logic ow, dd;
        logic       e_sr, e_mv; logic [7:0] e_md; logic e_ml, e_ds, chk_id; logic [7:0] e_id;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic r, logic sv, logic [7:0] sd, logic sl, logic mr,
                                logic [1:0] ia, logic [1:0] oa, logic [7:0] od, logic ow, logic dd,
                                logic sr, logic mv, logic [7:0] md, logic ml, logic ds, logic ci, logic [7:0] id);
        vec_t v;
        v.rst = r; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.ia = ia; v.oa = oa; v.od = od; v.ow = ow; v.dd = dd;
        v.e_sr = sr; v.e_mv = mv; v.e_md = md; v.e_ml = ml; v.e_ds = ds; v.chk_id = ci; v.e_id = id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_out [3];
        int n;
        exp_out[0] = 8'h11; exp_out[1] = 8'h22; exp_out[2] = 8'h7F;

        //            rst sv sd     sl mr ia oa od     ow dd   sr mv md     ml ds ci id
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h00)); // 0 reset
        vecs.push_back(mk(0, 1, 8'h01, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 1, 8'h01));
        vecs.push_back(mk(0, 1, 8'h03, 0, 0, 1, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 1, 8'h02));
        vecs.push_back(mk(0, 1, 8'h04, 1, 0, 2, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 1, 8'h03));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 2, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 8'h03)); // 5 START
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 3, 0, 8'h11, 1, 0,  0, 0, 8'h00, 0, 0, 1, 8'h04));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 8'hF0, 1, 0,  0, 0, 8'h00, 0, 0, 1, 8'h01));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 2, 8'h7F, 1, 1,  0, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h11, 0, 0, 0, 8'h00)); // 9 SEND
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,  0, 1, 8'hF0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,  0, 1, 8'hF0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'hF0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h7F, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'hAA, 1, 1,  1, 0, 8'h00, 0, 0, 0, 8'h00)); // 14 stray wr/done
        vecs.push_back(mk(0, 1, 8'hA1, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hA2, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hA3, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hA4, 1, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 8'hA1)); // 22 START
        vecs.push_back(mk(0, 1, 8'hEE, 0, 0, 1, 1, 8'h22, 1, 0,  0, 0, 8'h00, 0, 0, 1, 8'hA2));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 0, 2, 3, 8'h55, 1, 0,  0, 0, 8'h00, 0, 0, 1, 8'hA3));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 0, 3, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 0, 1, 8'hA4));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h11, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h22, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hEE, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h7F, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hB1, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00)); // 30 partial frame
        vecs.push_back(mk(0, 1, 8'hB2, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 8'hCC, 0, 0, 0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hC1, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 1, 8'hB1));
        vecs.push_back(mk(0, 1, 8'hC2, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 1, 8'hC1));
        vecs.push_back(mk(0, 1, 8'hC3, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hC4, 1, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 3, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1, 8'hC4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 0, 1, 8'hC2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h11, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h22, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0,  0, 1, 8'h7F, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8'h00));

        rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        in_adr = '0; out_adr = '0; out_data = '0; out_wr = 1'b0; dense_done = 1'b0;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; s_tvalid = vecs[i].sv; s_tdata = vecs[i].sd; s_tlast = vecs[i].sl;
            m_tready = vecs[i].mr; in_adr = vecs[i].ia; out_adr = vecs[i].oa; out_data = vecs[i].od;
            out_wr = vecs[i].ow; dense_done = vecs[i].dd;
            #1;
            chk($sformatf("row%0d s_tready", i), {7'd0, s_tready}, {7'd0, vecs[i].e_sr});
            chk($sformatf("row%0d m_tvalid", i), {7'd0, m_tvalid}, {7'd0, vecs[i].e_mv});
            chk($sformatf("row%0d m_tdata", i), m_tdata, vecs[i].e_md);
            chk($sformatf("row%0d m_tlast", i), {7'd0, m_tlast}, {7'd0, vecs[i].e_ml});
            chk($sformatf("row%0d dense_start", i), {7'd0, dense_start}, {7'd0, vecs[i].e_ds});
            chk($sformatf("row%0d err", i), {7'd0, err}, 8'h00);
            if (vecs[i].chk_id) chk($sformatf("row%0d bufferIn_data", i), in_data, vecs[i].e_id);
            $display("row %0d: sr=%b mv=%b md=%h ml=%b ds=%b id=%h", i, s_tready, m_tvalid, m_tdata, m_tlast, dense_start, in_data);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; out_wr = 1'b0; dense_done = 1'b0;

        // Misplaced tlast on beat 2; frame still counts 4 beats.
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1; s_tdata = 8'hD1 + 8'(i); s_tlast = (i == 1);
            step();
            chk($sformatf("tlast_err_beat%0d", i), {7'd0, err}, {7'd0, TLAST_CHK && (i >= 1)});
            $display("tlast beat %0d: err=%b", i, err);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        n = 0;
        while (!dense_start && n < 8) begin step(); n++; end
        chk("start_seen", {7'd0, dense_start}, 8'h01);
        step();
        dense_done = 1'b1;
        step();
        dense_done = 1'b0;
        n = 0;
        while (!m_tvalid && n < 8) begin step(); n++; end
        chk("send_seen", {7'd0, m_tvalid}, 8'h01);
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #0;
            chk($sformatf("drain%0d tdata", k), m_tdata, exp_out[k]);
            chk($sformatf("drain%0d tlast", k), {7'd0, m_tlast}, {7'd0, k == 2});
            $display("drain beat %0d: tdata=%h tlast=%b err=%b", k, m_tdata, m_tlast, err);
            step();
        end
        m_tready = 1'b0;
        chk("err_sticky", {7'd0, err}, {7'd0, TLAST_CHK});
        chk("ready_after_drain", {7'd0, s_tready}, 8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("err_cleared", {7'd0, err}, 8'h00);
        chk("ready_after_rst", {7'd0, s_tready}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dense_axis_bridge.md
Name: dense_axis_bridge

Overview:
- AXI-Stream front/back end for the dense layer datapath. Receives one input vector of IN_COUNT words on a slave stream and stores it in an input buffer; the datapath reads that buffer by address.
- Starts the dense controller, captures the OUT_COUNT results the datapath writes, then drains them on a master stream.
- This block writes the input buffer and reads the output buffer; the datapath does the opposite on both.

Parameters:
- IN_COUNT, 16, words per input frame and input buffer depth (>=2).
- OUT_COUNT, 10, words per output frame and output buffer depth (>=2).
- DATA_SIZE, 8, word width in bits, signed two's complement.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_SIZE  input stream data.
- s_axis_tvalid  in  1  input stream valid.
- s_axis_tready  out  1  input stream ready.
- s_axis_tlast  in  1  input stream end-of-frame.
- m_axis_tdata  out  DATA_SIZE  output stream data.
- m_axis_tvalid  out  1  output stream valid.
- m_axis_tready  in  1  output stream ready.
- m_axis_tlast  out  1  output stream end-of-frame.
- bufferIn_adr  in  $clog2(IN_COUNT)  datapath input read address.
- bufferIn_data  out  DATA_SIZE  input buffer word at bufferIn_adr.
- bufferOut_adr  in  $clog2(OUT_COUNT)  datapath result write address.
- bufferOut_data  in  DATA_SIZE  datapath result word.
- bufferOut_wr  in  1  result write strobe.
- dense_start  out  1  one-cycle start pulse to the dense controller.
- dense_done  in  1  dense controller finished all outputs.
- err  out  1  sticky framing error flag.

Behaviour:
- Storage: inBuf[IN_COUNT], outBuf[OUT_COUNT], DATA_SIZE-bit registers. Neither buffer is cleared by rst.
- Input buffer read: bufferIn_data = inBuf[bufferIn_adr], combinational, zero latency. An address >= IN_COUNT returns 0.
- FSM states: RECV -> START -> CALC -> SEND -> RECV. Reset state is RECV.
- Reset values: wr_cnt=0, rd_cnt=0, dense_start=0, m_axis_tvalid=0, m_axis_tlast=0, err=0. m_axis_tdata=0 whenever m_axis_tvalid=0. s_axis_tready=0 while rst=1.
- Reset mid-operation: rst aborts any frame. The partial frame is discarded, the FSM returns to RECV, and err is cleared.
- RECV:
  - s_axis_tready=1.
  - On handshake (tvalid&tready): inBuf[wr_cnt]<=tdata, wr_cnt++.
  - Handshake with wr_cnt==IN_COUNT-1: wr_cnt<=0, go to START.
  - tvalid=0 stalls with no state change.
- START: s_axis_tready=0; dense_start=1 for exactly this cycle; next state CALC.
- CALC:
  - s_axis_tready=0.
  - bufferOut_wr=1 writes outBuf[bufferOut_adr]<=bufferOut_data at the clock edge. Addresses >= OUT_COUNT are dropped.
  - dense_done=1 moves to SEND. A write in the same cycle as dense_done is committed.
  - dense_done is ignored in every other state. bufferOut_wr outside CALC is ignored.
- SEND:
  - m_axis_tvalid=1; m_axis_tdata=outBuf[rd_cnt]; m_axis_tlast=(rd_cnt==OUT_COUNT-1).
  - On tvalid&tready: rd_cnt++. On the last beat: rd_cnt<=0, go to RECV.
  - m_axis_tready=0 holds tdata, tlast and tvalid stable, per AXIS rules.
- Latency:
  - Last input beat to dense_start: 1 cycle.
  - dense_done to first m_axis_tvalid: 1 cycle.
  - Last output beat to s_axis_tready=1: 1 cycle.
- Throughput: one beat per cycle in RECV and SEND. No frame overlap; a new input frame is not accepted until the previous output frame is fully drained.
- s_axis_tlast: frame length is counted only; tlast is ignored unless TLAST_CHECK_EN is defined.

Optional Feature:
- Macro: DENSE_AXIS_BRIDGE_TLAST_CHECK_EN.
- Defined: on each RECV handshake, err<=1 if (tlast=1 and wr_cnt!=IN_COUNT-1) or (tlast=0 and wr_cnt==IN_COUNT-1).
  - err is sticky until rst.
  - The frame is still counted by IN_COUNT; there is no resynchronisation.
- Undefined: err tied to 0 and s_axis_tlast unused.

Test Plan (IN_COUNT=4, OUT_COUNT=3, DATA_SIZE=8):
- Reset then 4 beats 0x01,0x02,0x03,0x04 with tlast on beat 4 -> s_axis_tready drops after beat 4; dense_start=1 for exactly 1 cycle, one cycle later; bufferIn_adr=2 reads 0x03.
- In CALC, writes adr0=0x11, adr1=0xF0, adr2=0x7F, with adr2 in the same cycle as dense_done -> output beats 0x11,0xF0,0x7F, tlast only on the third beat.
- m_axis_tready toggling 1,0,0,1,1 during SEND -> no beat lost or duplicated; tdata stable while stalled; s_axis_tready=1 the cycle after the last beat.
- s_axis_tvalid pulsed every other cycle, plus s_axis_tvalid=1 during CALC -> all 4 words captured in order; no words accepted in START, CALC or SEND.
- rst asserted after 2 input beats -> outputs at reset values; the next 4 beats form a fresh frame and inBuf[0] holds the new first word.
- With the macro defined, tlast on beat 2 -> err=1 and stays 1 through the full frame; without the macro -> err=0.
